// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access sizes, FSM states and
// the alignment predicate also used by the core's MEM stage.
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    // Illegal sizes are reported separately, so they are not "misaligned" here.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_HALF: misaligned = addr_lo[0];
            SIZE_WORD: misaligned = (addr_lo != 2'b00);
            default:   misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering between a 32-bit memory word and a right-aligned
// byte/half/word access: load extraction with extension, store byte-enable merge.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mem_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] wdata_rep;
    logic [31:0] bit_mask;

    always_comb begin
        ld_byte = 8'(mem_word >> {addr_lo, 3'b000});
        ld_half = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];

        case (size)
            SIZE_BYTE: load_data = {{24{is_signed & ld_byte[7]}}, ld_byte};
            SIZE_HALF: load_data = {{16{is_signed & ld_half[15]}}, ld_half};
            default:   load_data = mem_word;
        endcase
    end

    // Replicate the store data across lanes; byte_en picks the lane(s) that land.
    always_comb begin
        case (size)
            SIZE_BYTE: begin
                wdata_rep = {4{wdata[7:0]}};
                byte_en   = 4'b0001 << addr_lo;
            end
            SIZE_HALF: begin
                wdata_rep = {2{wdata[15:0]}};
                byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            SIZE_WORD: begin
                wdata_rep = wdata;
                byte_en   = 4'b1111;
            end
            default: begin
                wdata_rep = wdata;
                byte_en   = 4'b0000;
            end
        endcase

        bit_mask   = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};
        store_word = (mem_word & ~bit_mask) | (wdata_rep & bit_mask);
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request and response, a word RAM,
// programmable wait states, and error reporting instead of corrupting storage.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;
    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [1:0]    size_q, size_d;
    logic          signed_q, signed_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          error_q, error_d;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          cur_write, cur_signed, acc_error, commit, mem_we;
    logic [1:0]    cur_size;
    logic [31:0]   cur_addr, cur_wdata, mem_word, load_data, store_word;
    logic [3:0]    byte_en;
    logic [AW-1:0] word_idx;

    // With zero wait states the commit happens on the accept edge, so the live
    // request is used; otherwise the latched copy is.
    always_comb begin
        if (state_q == IDLE) begin
            cur_write  = req_write;
            cur_size   = req_size;
            cur_signed = req_signed;
            cur_addr   = req_addr;
            cur_wdata  = req_wdata;
        end else begin
            cur_write  = write_q;
            cur_size   = size_q;
            cur_signed = signed_q;
            cur_addr   = addr_q;
            cur_wdata  = wdata_q;
        end
        word_idx  = cur_addr[AW+1:2];
        mem_word  = mem[word_idx];
        acc_error = (cur_size == SIZE_ILLEGAL) || misaligned(cur_size, cur_addr[1:0]) ||
                    (cur_addr >= ADDR_LIMIT);
    end

    dmem_lane_align u_lane_align (
        .size       (cur_size),
        .is_signed  (cur_signed),
        .addr_lo    (cur_addr[1:0]),
        .mem_word   (mem_word),
        .wdata      (cur_wdata),
        .load_data  (load_data),
        .byte_en    (byte_en),
        .store_word (store_word)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        size_d     = size_q;
        signed_d   = signed_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        error_d    = error_q;
        commit     = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    write_d  = req_write;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        commit  = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
            error_d = acc_error;
            rdata_d = (acc_error || cur_write) ? 32'h0 : load_data;
        end

        mem_we = commit && cur_write && !acc_error && (byte_en != 4'b0000);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            size_q   <= SIZE_BYTE;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            error_q  <= error_d;
        end
    end

    // RAM survives reset; a store whose commit edge coincides with reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem[word_idx] <= store_word;
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_error = error_q;

endmodule
